// File: rtl/seg_scan4.sv
// -----------------------------------------------------------------------------
// seg_scan4 - four-digit multiplexed seven-segment display driver.
//
// Captures four BCD digits plus the counter chain's overflow flag into a
// shadow register. It then time-multiplexes the digits onto a common-anode
// display. Each digit slot lasts SCAN_DIV cycles. The first cycle of a slot
// is dark, as an anti-ghosting gap. All outputs are registered.
//
// Optional feature: define SEG_LZB_EN to enable leading-zero blanking on
// digits 3..1. Digit 0 is never blanked.
//
// Ports:
//   clk    in   system clock, rising edge
//   clr_n  in   asynchronous active-low reset
//   en     in   scan enable; low freezes scanning and darkens the display
//   ld_n   in   synchronous active-low capture of bcd into the shadow
//   bcd    in   four BCD digits, [3:0] = digit 0 (rightmost)
//   ovf    in   overflow/carry flag, sampled every edge (sticky)
//   seg    out  segment cathodes {g,f,e,d,c,b,a}, active-low
//   dp_n   out  decimal point, active-low (overflow indicator on digit 3)
//   an_n   out  digit anodes, active-low one-hot
//   frame  out  one-cycle pulse at the end of each four-digit scan
// -----------------------------------------------------------------------------
module seg_scan4 #(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic        clk,
   input  logic        clr_n,
   input  logic        en,
   input  logic        ld_n,
   input  logic [15:0] bcd,
   input  logic        ovf,
   output logic [6:0]  seg,
   output logic        dp_n,
   output logic [3:0]  an_n,
   output logic        frame
);

   localparam int unsigned PW = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

   localparam logic [6:0] SEG_DARK = 7'h7F;

   logic [15:0]   shadow_q, shadow_d;
   logic          ovf_flag_q, ovf_flag_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [1:0]    idx_q, idx_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_n_q, dp_n_d;
   logic [3:0]    an_n_q, an_n_d;
   logic          frame_q, frame_d;

   logic [3:0]    digit;
   logic          lit;
   logic          blank;
   logic          wrap;

   // Active-low hex patterns; codes 10..15 show a dash (segment g only).
   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h3F;
      endcase
      return s;
   endfunction

   // Digit of the current slot.
   always_comb begin
      digit = shadow_q[3:0];
      unique case (idx_q)
         2'd0: digit = shadow_q[3:0];
         2'd1: digit = shadow_q[7:4];
         2'd2: digit = shadow_q[11:8];
         2'd3: digit = shadow_q[15:12];
      endcase
   end

`ifdef SEG_LZB_EN
   // A digit is blanked when it and every more-significant digit are zero.
   // Invalid codes are nonzero and therefore stop the blanking.
   logic [3:0] nz;
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         nz[i] = (shadow_q[4*i +: 4] != 4'd0);
      end
      blank = 1'b0;
      unique case (idx_q)
         2'd0: blank = 1'b0;
         2'd1: blank = ~(nz[3] | nz[2] | nz[1]);
         2'd2: blank = ~(nz[3] | nz[2]);
         2'd3: blank = ~nz[3];
      endcase
   end
`else
   assign blank = 1'b0;
`endif

   // Next-state: shadow capture, sticky overflow, prescaler and digit index.
   always_comb begin
      shadow_d   = shadow_q;
      ovf_flag_d = ovf_flag_q;
      presc_d    = presc_q;
      idx_d      = idx_q;
      wrap       = (presc_q == PRESC_MAX);

      if (!ld_n) begin
         shadow_d = bcd;
      end

      // A set on the same edge as a capture takes priority over the clear.
      if (ovf) begin
         ovf_flag_d = 1'b1;
      end else if (!ld_n) begin
         ovf_flag_d = 1'b0;
      end

      if (en) begin
         if (wrap) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
         end else begin
            presc_d = presc_q + 1'b1;
         end
      end
   end

   // Registered outputs, computed from the pre-edge state.
   always_comb begin
      lit     = en && (presc_q != '0);
      an_n_d  = 4'hF;
      seg_d   = SEG_DARK;
      dp_n_d  = 1'b1;
      frame_d = en && wrap && (idx_q == 2'd3);

      if (lit) begin
         an_n_d = ~(4'b0001 << idx_q);
         seg_d  = blank ? SEG_DARK : decode(digit);
         dp_n_d = ~((idx_q == 2'd3) && ovf_flag_q);
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         shadow_q   <= 16'h0000;
         ovf_flag_q <= 1'b0;
         presc_q    <= '0;
         idx_q      <= 2'd0;
         seg_q      <= SEG_DARK;
         dp_n_q     <= 1'b1;
         an_n_q     <= 4'hF;
         frame_q    <= 1'b0;
      end else begin
         shadow_q   <= shadow_d;
         ovf_flag_q <= ovf_flag_d;
         presc_q    <= presc_d;
         idx_q      <= idx_d;
         seg_q      <= seg_d;
         dp_n_q     <= dp_n_d;
         an_n_q     <= an_n_d;
         frame_q    <= frame_d;
      end
   end

   assign seg   = seg_q;
   assign dp_n  = dp_n_q;
   assign an_n  = an_n_q;
   assign frame = frame_q;

endmodule

// File: tb/tb_seg_scan4.sv
// -----------------------------------------------------------------------------
// tb_seg_scan4 - self-checking bench for seg_scan4 with SCAN_DIV = 4.
// A cycle model predicts every registered output. Predictions are queued when
// inputs are driven and compared one cycle later. A vector table checks the
// decoded segment values of each slot against hand-written constants.
// -----------------------------------------------------------------------------
module tb_seg_scan4;

   localparam int unsigned SCAN_DIV = 4;

   logic        clk = 1'b0;
   logic        clr_n;
   logic        en;
   logic        ld_n;
   logic [15:0] bcd;
   logic        ovf;
   logic [6:0]  seg;
   logic        dp_n;
   logic [3:0]  an_n;
   logic        frame;

   always #5 clk = ~clk;

   seg_scan4 #(
      .SCAN_DIV(SCAN_DIV)
   ) dut (
      .clk   (clk),
      .clr_n (clr_n),
      .en    (en),
      .ld_n  (ld_n),
      .bcd   (bcd),
      .ovf   (ovf),
      .seg   (seg),
      .dp_n  (dp_n),
      .an_n  (an_n),
      .frame (frame)
   );

   typedef struct packed {
      logic [6:0] seg;
      logic       dp_n;
      logic [3:0] an_n;
      logic       frame;
   } out_t;

   typedef struct packed {
      logic [15:0]     bcd;
      logic [3:0][6:0] segs;
   } vec_t;

   int   n_checks = 0;
   int   n_pass   = 0;
   out_t exp_q[$];

   // Cycle model state (mirrors the DUT state after each edge).
   logic [15:0] m_shadow;
   logic        m_ovf;
   int          m_presc;
   int          m_idx;
   logic        last_lit;
   int          last_idx;

   vec_t vecs[6];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0: s = 7'h40;  4'd1: s = 7'h79;  4'd2: s = 7'h24;  4'd3: s = 7'h30;
         4'd4: s = 7'h19;  4'd5: s = 7'h12;  4'd6: s = 7'h02;  4'd7: s = 7'h78;
         4'd8: s = 7'h00;  4'd9: s = 7'h10;
         default: s = 7'h3F;
      endcase
      return s;
   endfunction

   function automatic vec_t mk(input logic [15:0] b, input logic [6:0] s3, input logic [6:0] s2,
                               input logic [6:0] s1, input logic [6:0] s0);
      vec_t v;
      v.bcd     = b;
      v.segs[3] = s3;
      v.segs[2] = s2;
      v.segs[1] = s1;
      v.segs[0] = s0;
      return v;
   endfunction

   task automatic model_reset();
      m_shadow = 16'h0;
      m_ovf    = 1'b0;
      m_presc  = 0;
      m_idx    = 0;
      exp_q.delete();
   endtask

   // Predict the outputs of the coming edge, advance the model, then compare.
   task automatic tick();
      out_t e;
      out_t got;
      logic lit;
      logic blank;
      lit   = en && (m_presc != 0);
      blank = 1'b0;
`ifdef SEG_LZB_EN
      blank = (m_idx != 0) && ((m_shadow >> (4 * m_idx)) == 16'h0);
`endif
      e.frame = en && (m_presc == SCAN_DIV - 1) && (m_idx == 3);
      e.an_n  = lit ? ~(4'b0001 << m_idx) : 4'hF;
      e.seg   = (lit && !blank) ? seg_of(m_shadow[4*m_idx +: 4]) : 7'h7F;
      e.dp_n  = !(lit && (m_idx == 3) && m_ovf);
      exp_q.push_back(e);
      last_lit = lit;
      last_idx = m_idx;

      if (!ld_n) m_shadow = bcd;
      if (ovf) m_ovf = 1'b1;
      else if (!ld_n) m_ovf = 1'b0;
      if (en) begin
         if (m_presc == SCAN_DIV - 1) begin
            m_presc = 0;
            m_idx   = (m_idx + 1) % 4;
         end else begin
            m_presc++;
         end
      end

      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_checks++;
         $display("FAIL sb_empty: got no prediction, expected one at %0t", $time);
      end else begin
         got = exp_q.pop_front();
         check("sb_seg", {9'b0, seg}, {9'b0, got.seg});
         check("sb_dp_n", {15'b0, dp_n}, {15'b0, got.dp_n});
         check("sb_an_n", {12'b0, an_n}, {12'b0, got.an_n});
         check("sb_frame", {15'b0, frame}, {15'b0, got.frame});
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_seg"}, {9'b0, seg}, 16'h007F);
      check({tag, "_dp_n"}, {15'b0, dp_n}, 16'h0001);
      check({tag, "_an_n"}, {12'b0, an_n}, 16'h000F);
      check({tag, "_frame"}, {15'b0, frame}, 16'h0000);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt;
      int gap;
      bit found;

      vecs[0] = mk(16'h1234, 7'h79, 7'h24, 7'h30, 7'h19);
      vecs[1] = mk(16'h9876, 7'h10, 7'h00, 7'h78, 7'h02);
      vecs[2] = mk(16'h50F0, 7'h12, 7'h40, 7'h3F, 7'h40);
`ifdef SEG_LZB_EN
      vecs[3] = mk(16'h00A5, 7'h7F, 7'h7F, 7'h3F, 7'h12);
      vecs[4] = mk(16'h0007, 7'h7F, 7'h7F, 7'h7F, 7'h78);
      vecs[5] = mk(16'h0000, 7'h7F, 7'h7F, 7'h7F, 7'h40);
`else
      vecs[3] = mk(16'h00A5, 7'h40, 7'h40, 7'h3F, 7'h12);
      vecs[4] = mk(16'h0007, 7'h40, 7'h40, 7'h40, 7'h78);
      vecs[5] = mk(16'h0000, 7'h40, 7'h40, 7'h40, 7'h40);
`endif

      clr_n = 1'b0;
      en    = 1'b0;
      ld_n  = 1'b1;
      bcd   = 16'h0;
      ovf   = 1'b0;
      model_reset();
      #22;
      check_reset_outputs("init_rst");
      clr_n = 1'b1;
      en    = 1'b1;

      // First edge after reset release is still dark.
      tick();
      check("release_dark_an", {12'b0, an_n}, 16'h000F);

      // Table-driven decode per slot.
      foreach (vecs[v]) begin
         bcd  = vecs[v].bcd;
         ld_n = 1'b0;
         tick();
         ld_n = 1'b1;
         for (int c = 0; c < 4 * SCAN_DIV; c++) begin
            tick();
            if (last_lit) check($sformatf("tbl%0d_seg%0d", v, last_idx), {9'b0, seg},
                                {9'b0, vecs[v].segs[last_idx]});
         end
      end

      // Frame period is four slots.
      bcd   = 16'h1234;
      ld_n  = 1'b0;
      tick();
      ld_n  = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         tick();
         found = (frame === 1'b1);
      end
      check("frame_seen", {15'b0, found}, 16'h0001);
      gap   = 0;
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         tick();
         gap++;
         found = (frame === 1'b1);
      end
      check("frame_period", gap[15:0], 16'(4 * SCAN_DIV));

      // Sticky overflow lights dp only in the lit cycles of slot 3.
      ovf = 1'b1;
      tick();
      ovf = 1'b0;
      for (int f = 0; f < 2; f++) begin
         cnt = 0;
         for (int c = 0; c < 4 * SCAN_DIV; c++) begin
            tick();
            if (dp_n === 1'b0) begin
               cnt++;
               check("dp_slot_an", {12'b0, an_n}, 16'h0007);
            end
         end
         check("dp_lit_count", cnt[15:0], 16'(SCAN_DIV - 1));
      end
      ld_n = 1'b0;
      tick();
      ld_n = 1'b1;
      cnt  = 0;
      for (int c = 0; c < 4 * SCAN_DIV; c++) begin
         tick();
         if (dp_n === 1'b0) cnt++;
      end
      check("dp_cleared", cnt[15:0], 16'h0000);
      ld_n = 1'b0;
      ovf  = 1'b1;
      tick();
      ld_n = 1'b1;
      ovf  = 1'b0;
      cnt  = 0;
      for (int c = 0; c < 4 * SCAN_DIV; c++) begin
         tick();
         if (dp_n === 1'b0) cnt++;
      end
      check("dp_set_wins", cnt[15:0], 16'(SCAN_DIV - 1));

      // Freeze scanning mid slot 2, then resume at the held position.
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         tick();
         found = (m_idx == 2) && (m_presc == 2);
      end
      check("en_slot_found", {15'b0, found}, 16'h0001);
      en = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         check("en_off_an", {12'b0, an_n}, 16'h000F);
         check("en_off_frame", {15'b0, frame}, 16'h0000);
      end
      en = 1'b1;
      tick();
      check("resume_an0", {12'b0, an_n}, 16'h000B);
      check("resume_seg0", {9'b0, seg}, 16'h0024);
      tick();
      check("resume_an1", {12'b0, an_n}, 16'h000B);
      tick();
      check("resume_dark", {12'b0, an_n}, 16'h000F);
      tick();
      check("resume_next", {12'b0, an_n}, 16'h0007);

      // Asynchronous reset mid slot, away from any clock edge.
      tick();
      #3;
      clr_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      model_reset();
      @(negedge clk);
      check_reset_outputs("async_hold");
      clr_n = 1'b1;
      tick();
      check("post_rst_dark", {12'b0, an_n}, 16'h000F);
      tick();
      check("post_rst_slot0", {12'b0, an_n}, 16'h000E);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
